// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its arbiter front end: default data and
// opcode widths, the ALU opcode encoding used by every client, and the state
// encoding of the arbiter FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default widths used by the ALU datapath and its clients
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 4;

  // ALU opcode encoding shared by all requesters and the ALU itself
  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 4'h2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [ALU_OP_W-1:0] OP_SLL = 4'h5;
  localparam logic [ALU_OP_W-1:0] OP_SRL = 4'h6;
  localparam logic [ALU_OP_W-1:0] OP_SRA = 4'h7;
  localparam logic [ALU_OP_W-1:0] OP_BEQ = 4'h8;
  localparam logic [ALU_OP_W-1:0] OP_BNE = 4'h9;
  localparam logic [ALU_OP_W-1:0] OP_BLT = 4'hA;
  localparam logic [ALU_OP_W-1:0] OP_BGE = 4'hB;

  // Arbiter FSM: wait for a request, let the ALU settle, present the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Starting at i_ptr and walking upward
// (wrapping at NUM_REQ-1), the first asserted request wins.
// Ports:
//   i_req    [NUM_REQ-1:0]  request vector
//   i_ptr    [ID_W-1:0]     highest-priority index this cycle
//   o_grant  [NUM_REQ-1:0]  one-hot winner (zero when no request)
//   o_id     [ID_W-1:0]     binary index of the winner (0 when no request)
//   o_valid                 at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_valid
);

  // Walk the requesters in priority order; the first hit freezes the result.
  always_comb begin
    int idx;
    o_grant = '0;
    o_id    = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!o_valid && i_req[idx]) begin
        o_valid      = 1'b1;
        o_grant[idx] = 1'b1;
        o_id         = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU among NUM_REQ requesters. A request
// is accepted in an accept slot (IDLE, or RESP while the consumer takes the
// current result), its operands are registered onto the ALU inputs, the ALU
// output is captured one cycle later and held on a tagged response channel
// until rsp_ready.
// Optional feature macro: ALU_ARB_LOCK_EN -- a requester that accepts with
//   req_lock=1 keeps exclusive grant of the next accept slot while it holds
//   req_valid. Without the macro req_lock is ignored.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready [NUM_REQ]   request handshake per requester
//   req_a1/req_a2 [NUM_REQ*DATA_W]  packed operands, slot i at [i*DATA_W +: DATA_W]
//   req_op [NUM_REQ*OP_W]           packed opcodes
//   req_lock [NUM_REQ]              hold grant for next op (lock build only)
//   alu_a1/alu_a2/alu_op            registered operands to the ALU
//   alu_aout/alu_zero_i             combinational result from the ALU
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_result/rsp_zero      owner tag and captured ALU result
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a1,
  input  logic [NUM_REQ*DATA_W-1:0] req_a2,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [DATA_W-1:0]         alu_a1,
  output logic [DATA_W-1:0]         alu_a2,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_aout,
  input  logic                      alu_zero_i,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_cur_id;
  logic [DATA_W-1:0]  r_alu_a1;
  logic [DATA_W-1:0]  r_alu_a2;
  logic [OP_W-1:0]    r_alu_op;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [DATA_W-1:0]  r_rsp_result;
  logic               r_rsp_zero;

  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [ID_W-1:0]    w_win_id;
  logic               w_win_any;
  logic               w_accept_slot;
  logic               w_accept;
  logic               w_locked_grant;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [DATA_W-1:0]  w_sel_a1;
  logic [DATA_W-1:0]  w_sel_a2;
  logic [OP_W-1:0]    w_sel_op;

`ifdef ALU_ARB_LOCK_EN
  logic            r_lock_active;
  logic [ID_W-1:0] r_lock_id;

  // While a lock is held and its owner still requests, only the owner is
  // visible to the arbiter; everyone else stalls.
  always_comb begin
    w_locked_grant = r_lock_active && req_valid[r_lock_id];
    w_req_eff      = req_valid;
    if (w_locked_grant) begin
      w_req_eff            = '0;
      w_req_eff[r_lock_id] = 1'b1;
    end
  end

  // The lock follows the req_lock bit of each accepted op, and is released
  // early if the owner is seen without a request in an accept slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_active <= 1'b0;
      r_lock_id     <= '0;
    end else if (w_accept) begin
      r_lock_active <= req_lock[w_win_id];
      r_lock_id     <= w_win_id;
    end else if (w_accept_slot && r_lock_active && !req_valid[r_lock_id]) begin
      r_lock_active <= 1'b0;
    end
  end
`else
  logic w_unused_lock;

  // Lock requests have no effect in the plain round-robin build.
  always_comb begin
    w_locked_grant = 1'b0;
    w_req_eff      = req_valid;
    w_unused_lock  = ^req_lock;
  end
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_arbiter (
    .i_req  (w_req_eff),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_win_onehot),
    .o_id   (w_win_id),
    .o_valid(w_win_any)
  );

  // A new op may be taken when nothing is in flight, or when the current
  // result leaves this very cycle (back-to-back issue).
  always_comb begin
    w_accept_slot = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
    w_accept      = w_accept_slot && w_win_any;
  end

  // Pointer moves just past the winner, wrapping at the last requester.
  always_comb begin
    if (w_win_id == ID_W'(NUM_REQ - 1)) w_ptr_nxt = '0;
    else                                w_ptr_nxt = w_win_id + 1'b1;
  end

  // Operand mux: select the winner's slice from the packed request buses.
  always_comb begin
    w_sel_a1 = '0;
    w_sel_a2 = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == ID_W'(i)) begin
        w_sel_a1 = req_a1[i*DATA_W +: DATA_W];
        w_sel_a2 = req_a2[i*DATA_W +: DATA_W];
        w_sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: EXEC always lasts one cycle; RESP waits for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = w_accept ? ST_EXEC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the grant strobe is only raised in an accept slot.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready = w_win_onehot;
  end

  // Issue side: capture the winner's operands on accept; the ALU inputs
  // otherwise hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a1 <= '0;
      r_alu_a2 <= '0;
      r_alu_op <= '0;
      r_cur_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_alu_a1 <= w_sel_a1;
      r_alu_a2 <= w_sel_a2;
      r_alu_op <= w_sel_op;
      r_cur_id <= w_win_id;
      if (!w_locked_grant) r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Response side: sample the ALU during EXEC, hold until the consumer takes
  // it. A same-cycle new accept still drops valid for its EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= r_cur_id;
      r_rsp_result <= alu_aout;
      r_rsp_zero   <= alu_zero_i;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign alu_a1     = r_alu_a1;
  assign alu_a2     = r_alu_a2;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter with a behavioural ALU attached.
// Honours ALU_ARB_LOCK_EN when choosing the expected grant order.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a1;
  logic [NUM_REQ*DATA_W-1:0] req_a2;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        req_lock;
  logic [DATA_W-1:0]         alu_a1;
  logic [DATA_W-1:0]         alu_a2;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_aout;
  logic                      alu_zero_i;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;

  int errors;
  int checks;

  typedef struct {
    int          id;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [3:0]  op;
    logic [31:0] expResult;
    logic        expZero;
  } vec_t;

  vec_t vecs[11];

  alu_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .ID_W   (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a1    (req_a1),
    .req_a2    (req_a2),
    .req_op    (req_op),
    .req_lock  (req_lock),
    .alu_a1    (alu_a1),
    .alu_a2    (alu_a2),
    .alu_op    (alu_op),
    .alu_aout  (alu_aout),
    .alu_zero_i(alu_zero_i),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational ALU
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_aout = alu_a1 + alu_a2;
      OP_SUB:  alu_aout = alu_a1 - alu_a2;
      OP_AND:  alu_aout = alu_a1 & alu_a2;
      OP_OR:   alu_aout = alu_a1 | alu_a2;
      OP_XOR:  alu_aout = alu_a1 ^ alu_a2;
      OP_SLL:  alu_aout = alu_a1 << alu_a2[4:0];
      OP_SRL:  alu_aout = alu_a1 >> alu_a2[4:0];
      OP_SRA:  alu_aout = $unsigned($signed(alu_a1) >>> alu_a2[4:0]);
      OP_BEQ:  alu_aout = {31'b0, alu_a1 == alu_a2};
      OP_BNE:  alu_aout = {31'b0, alu_a1 != alu_a2};
      default: alu_aout = '0;
    endcase
    alu_zero_i = (alu_aout == '0);
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one requester's operand slot
  task automatic setReq(input int i, input logic [31:0] a1, input logic [31:0] a2, input logic [3:0] op);
    req_a1[i*DATA_W +: DATA_W] = a1;
    req_a2[i*DATA_W +: DATA_W] = a2;
    req_op[i*OP_W +: OP_W]     = op;
  endtask

  // Reset the DUT and check the reset state
  task automatic doReset();
    req_valid = '0;
    req_lock  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_result", rsp_result, 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset alu_a1", alu_a1, 32'd0);
    checkOutput("reset alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  // Run one isolated op from an IDLE start and check every stage of it
  task automatic applyStimulus(input vec_t v);
    setReq(v.id, v.a1, v.a2, v.op);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    rsp_ready       = 1'b0;
    @(negedge clk);
    checkOutput("vec req_ready", 32'(req_ready), 32'd1 << v.id);
    tick();
    req_valid = '0;
    checkOutput("vec alu_op", 32'(alu_op), 32'(v.op));
    checkOutput("vec alu_a1", alu_a1, v.a1);
    checkOutput("vec rsp_valid early", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("vec rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("vec rsp_result", rsp_result, v.expResult);
    checkOutput("vec rsp_zero", 32'(rsp_zero), 32'(v.expZero));
    checkOutput("vec rsp_id", 32'(rsp_id), 32'(v.id));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("vec rsp_valid drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [3:0] expLock[4];

    errors    = 0;
    checks    = 0;
    req_a1    = '0;
    req_a2    = '0;
    req_op    = '0;
    req_valid = '0;
    req_lock  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    vecs[0]  = '{0, 32'd5,        32'd7,        OP_ADD, 32'd12,       1'b0};
    vecs[1]  = '{1, 32'd20,       32'd3,        OP_SUB, 32'd17,       1'b0};
    vecs[2]  = '{2, 32'hF0F0F0F0, 32'h0FF00FF0, OP_AND, 32'h00F000F0, 1'b0};
    vecs[3]  = '{3, 32'h12340000, 32'h00005678, OP_OR,  32'h12345678, 1'b0};
    vecs[4]  = '{0, 32'hA5A5A5A5, 32'hA5A5A5A5, OP_XOR, 32'h00000000, 1'b1};
    vecs[5]  = '{1, 32'd1,        32'd31,       OP_SLL, 32'h80000000, 1'b0};
    vecs[6]  = '{2, 32'h80000000, 32'd4,        OP_SRL, 32'h08000000, 1'b0};
    vecs[7]  = '{3, 32'h80000000, 32'd4,        OP_SRA, 32'hF8000000, 1'b0};
    vecs[8]  = '{0, 32'hFFFFFFFF, 32'd1,        OP_ADD, 32'h00000000, 1'b1};
    vecs[9]  = '{1, 32'd0,        32'd1,        OP_SUB, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{2, 32'd7,        32'd7,        OP_BEQ, 32'h00000001, 1'b0};

    doReset();

    $display("[TB] single requests from table");
    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    $display("[TB] fairness with all requesters active");
    doReset();
    for (int i = 0; i < NUM_REQ; i++) setReq(i, 32'(i * 10), 32'd1, OP_ADD);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c % 2 == 0) checkOutput("fair grant", 32'(req_ready), 32'd1 << ((c / 2) % 4));
      else            checkOutput("fair idle", 32'(req_ready), 32'd0);
      if (c >= 2 && c % 2 == 0) begin
        checkOutput("fair rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("fair rsp_id", 32'(rsp_id), 32'((c / 2 - 1) % 4));
        checkOutput("fair rsp_result", rsp_result, 32'(((c / 2 - 1) % 4) * 10 + 1));
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();

    $display("[TB] backpressure");
    setReq(2, 32'd9, 32'd9, OP_SUB);
    setReq(0, 32'd1, 32'd1, OP_ADD);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp grant r2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0101;
    @(negedge clk);
    checkOutput("bp exec no grant", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp rsp_result", rsp_result, 32'd0);
      checkOutput("bp rsp_zero", 32'(rsp_zero), 32'd1);
      checkOutput("bp rsp_id", 32'(rsp_id), 32'd2);
      checkOutput("bp stall", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release grant r0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    checkOutput("bp rsp_valid drop", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    rsp_ready = 1'b0;

    $display("[TB] pointer wrap");
    applyStimulus(vecs[2]);
    setReq(1, 32'd100, 32'd1, OP_ADD);
    setReq(3, 32'd300, 32'd1, OP_ADD);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("wrap first r3", 32'(req_ready), 32'h8);
    tick();
    tick();
    @(negedge clk);
    checkOutput("wrap rsp r3", 32'(rsp_id), 32'd3);
    checkOutput("wrap second r1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checkOutput("wrap rsp r1", rsp_result, 32'd101);
    tick();
    rsp_ready = 1'b0;

    $display("[TB] reset during EXEC");
    doReset();
    setReq(0, 32'd3, 32'd1, OP_SUB);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    checkOutput("rst pre alu_a1", alu_a1, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst async rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst async alu_a1", alu_a1, 32'd0);
    checkOutput("rst async alu_op", 32'(alu_op), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst no stale rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = '1;
    @(negedge clk);
    checkOutput("rst ptr back to 0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("[TB] lock sequence");
`ifdef ALU_ARB_LOCK_EN
    expLock[0] = 4'h2; expLock[1] = 4'h2; expLock[2] = 4'h2; expLock[3] = 4'h4;
`else
    expLock[0] = 4'h2; expLock[1] = 4'h4; expLock[2] = 4'h1; expLock[3] = 4'h2;
`endif
    req_valid = 4'b0111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_lock[1] = (c / 2 < 2);
      @(negedge clk);
      if (c % 2 == 0) checkOutput("lock grant", 32'(req_ready), 32'(expLock[c / 2]));
      tick();
    end
    req_valid = '0;
    req_lock  = '0;
    tick();
    tick();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
